// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage register:
// state encoding, occupancy/counter widths and per-stage payload layouts.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int OCC_W     = 2;
    localparam int CNT_W_DEF = 16;

    // W-stage payload layout, packed LSB first by the instantiating stage
    localparam int W_INSTR_LSB    = 0;
    localparam int W_DM_LSB       = 32;
    localparam int W_AO_LSB       = 64;
    localparam int W_PC8_LSB      = 96;
    localparam int W_A3_LSB       = 128;
    localparam int W_A3_W         = 5;
    localparam int W_MEMTOREG_LSB = 133;
    localparam int W_MEMTOREG_W   = 4;
    localparam int W_REGWRITE_BIT = 137;
    localparam int W_PAYLOAD_W    = 138;

    // The state encoding doubles as the occupancy count.
    function automatic logic [OCC_W-1:0] occ_of(input state_t s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of a pipeline stage: loads on demand and returns to
// the bubble value on reset or clear (clear wins over load).
module pipe_slot #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_reg <= BUBBLE_VAL;
        end else if (clear) begin
            q_reg <= BUBBLE_VAL;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush, bubble insertion and stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                SKID       = 1,
    parameter int                CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [OCC_W-1:0]  occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state_reg;
    state_t            state_next;
    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  stall_cnt_reg;

    assign out_valid = (state_reg != ST_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occ       = occ_of(state_reg);
    assign stall_cnt = stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (in_fire) state_next = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_next = (SKID != 0) ? ST_FULL : ST_ONE;
                    end else if (out_fire && !in_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL:  if (out_fire) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Slot controls: the main slot always holds the oldest entry, so out_data
    // is the bubble exactly when the stage is empty.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: main_load = in_fire;
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load  = 1'b1;
                        main_d     = skid_q;
                        skid_clear = 1'b1;
                    end
                end
                default: main_clear = 1'b1;
            endcase
        end
    end

    pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .clear (main_clear),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_reg;

            pipe_slot #(
                .DATA_W     (DATA_W),
                .BUBBLE_VAL (BUBBLE_VAL)
            ) u_skid (
                .clk   (clk),
                .reset (reset),
                .clear (skid_clear),
                .load  (skid_load),
                .d     (in_data),
                .q     (skid_q)
            );

            // Registered ready breaks the combinational path from out_ready.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    in_ready_reg <= 1'b0;
                end else begin
                    in_ready_reg <= (state_next != ST_FULL);
                end
            end

            assign in_ready = in_ready_reg;
        end else begin : g_noskid
            assign skid_q   = BUBBLE_VAL;
            assign in_ready = reset & (out_ready | ~out_valid);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: two stage configurations share one stimulus stream, each
// checked every cycle against a FIFO-queue reference model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        a_rdy, a_ov, b_rdy, b_ov;
    logic [31:0] a_od, b_od;
    logic [1:0]  a_occ, b_occ;
    logic [15:0] a_sc;
    logic [3:0]  b_sc;

    int checks    = 0;
    int failures  = 0;
    int delivered = 0;
    bit started   = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(32), .BUBBLE_VAL(32'h0000_0000), .SKID(1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_rdy),
        .out_valid(a_ov), .out_data(a_od), .out_ready(out_ready),
        .occ(a_occ), .stall_cnt(a_sc)
    );

    pipe_stage_reg #(
        .DATA_W(32), .BUBBLE_VAL(32'hFFFF_0000), .SKID(0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_rdy),
        .out_valid(b_ov), .out_data(b_od), .out_ready(out_ready),
        .occ(b_occ), .stall_cnt(b_sc)
    );

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, id, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] d, input logic ordy);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        localparam int          CAP  = (gi == 0) ? 2 : 1;
        localparam logic [31:0] BUB  = (gi == 0) ? 32'h0000_0000 : 32'hFFFF_0000;
        localparam int          CMAX = (gi == 0) ? 65535 : 15;

        logic [31:0] q[$];
        int          cnt = 0;
        logic        rdy = 1'b0;
        logic        dv, drdy;
        logic [31:0] dd;
        logic [1:0]  docc;
        logic [15:0] dsc;

        if (gi == 0) begin : g_sel_a
            assign dv = a_ov; assign drdy = a_rdy; assign dd = a_od;
            assign docc = a_occ; assign dsc = a_sc;
        end else begin : g_sel_b
            assign dv = b_ov; assign drdy = b_rdy; assign dd = b_od;
            assign docc = b_occ; assign dsc = {12'h000, b_sc};
        end

        always @(negedge clk) begin
            if (started) begin : body
                logic ev, er;
                ev = (q.size() != 0);
                er = (gi == 0) ? rdy : (reset & (out_ready | ~ev));
                chk("occ", gi, 32'(docc), 32'(q.size()));
                chk("out_valid", gi, 32'(dv), 32'(ev));
                chk("out_data", gi, dd, ev ? q[0] : BUB);
                chk("in_ready", gi, 32'(drdy), 32'(er));
                chk("stall_cnt", gi, 32'(dsc), 32'(cnt));
                // advance the model across the coming posedge
                if (!reset) begin
                    q.delete();
                    cnt = 0;
                    rdy = 1'b0;
                end else begin
                    if (ev && !out_ready && cnt < CMAX) cnt++;
                    if (ev && out_ready) begin
                        void'(q.pop_front());
                        delivered++;
                    end
                    if (flush) q.delete();
                    else if (in_valid && er) q.push_back(in_data);
                    rdy = (q.size() < CAP);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // streaming
        for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, 1'b1, 32'(i), 1'b1);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // fill the skid, then drain
        drive(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // flush while full with a simultaneous input
        drive(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // long stall to saturate the narrow counter, then reset clears it
        drive(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
        repeat (20) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 6));
        end
        repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("delivered_min", 0, 32'(delivered > 100), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
